// File: rtl/cnn_core_pkg.sv
// Shared types, widths and helpers for the CNN core datapath.
//   PROD_W / ACC_W / ACT_W : default product, accumulator and activation widths
//   prod_t / acc_t / act_t : signed data types at those widths
//   accum_state_e          : window accumulator state (FIRST / ACCUM)
//   sat_shift_round()      : round-half-up, arithmetic shift, optional ReLU,
//                            saturate an accumulator value to an activation
package cnn_core_pkg;

  localparam int PROD_W = 21;
  localparam int ACC_W  = 32;
  localparam int ACT_W  = 16;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [ACT_W-1:0]  act_t;

  typedef enum logic [0:0] {
    FIRST = 1'b0,
    ACCUM = 1'b1
  } accum_state_e;

  // One extra bit of headroom so the rounding add can never wrap.
  function automatic act_t sat_shift_round(input acc_t a, input int unsigned shift,
                                           input logic relu);
    logic signed [ACC_W:0] v;
    logic signed [ACC_W:0] v_max;
    logic signed [ACC_W:0] v_min;
    v_max = {{(ACC_W-ACT_W+2){1'b0}}, {(ACT_W-1){1'b1}}};
    v_min = {{(ACC_W-ACT_W+2){1'b1}}, {(ACT_W-1){1'b0}}};
    v = {a[ACC_W-1], a};
    if (shift != 0) begin
      v = v + ((ACC_W+1)'(1) << (shift - 1));
    end else begin
      v = v;
    end
    v = v >>> shift;
    if (relu && v[ACC_W]) begin
      v = '0;
    end else if (v > v_max) begin
      v = v_max;
    end else if (v < v_min) begin
      v = v_min;
    end else begin
      v = v;
    end
    return act_t'(v[ACT_W-1:0]);
  endfunction

endpackage

// File: rtl/cnn_core_requant.sv
// Combinational requantizer: (s + 2^(SHIFT-1)) >>> SHIFT, optional ReLU,
// saturation to a signed OUT_WIDTH activation. Also used by the pooling stage.
//   i_acc : signed ACC_WIDTH input sum
//   o_act : signed OUT_WIDTH activation
module cnn_core_requant
  import cnn_core_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_W,
  parameter int OUT_WIDTH = ACT_W,
  parameter int SHIFT     = 4,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic signed [OUT_WIDTH-1:0] o_act
);

  // Half an output LSB; evaluates to zero when SHIFT is 0.
  localparam logic signed [ACC_WIDTH:0] RND     = ((ACC_WIDTH+1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] w_ext;
  logic signed [ACC_WIDTH:0] w_shr;
  logic signed [ACC_WIDTH:0] w_val;

  // Round, shift, clamp.
  always_comb begin
    w_ext = {i_acc[ACC_WIDTH-1], i_acc};
    w_shr = (w_ext + RND) >>> SHIFT;
    if (RELU_EN && w_shr[ACC_WIDTH]) begin
      w_val = '0;
    end else if (w_shr > SAT_MAX) begin
      w_val = SAT_MAX;
    end else if (w_shr < SAT_MIN) begin
      w_val = SAT_MIN;
    end else begin
      w_val = w_shr;
    end
  end

  assign o_act = w_val[OUT_WIDTH-1:0];

endmodule

// File: rtl/cnn_core_conv_accum.sv
// Convolution window accumulator: sums TAPS signed products plus a per-window
// bias, then requantizes to one activation per window.
//   ap_clk/ap_rst_n          : clock, async active-low reset
//   in_data/in_last/in_bias  : product stream (bias taken on first beat)
//   in_valid/in_ready        : input handshake
//   out_data/out_valid/out_ready : registered result stream
//   err_tap                  : sticky, some window length differed from TAPS
module cnn_core_conv_accum
  import cnn_core_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_W,
  parameter int ACC_WIDTH  = ACC_W,
  parameter int BIAS_WIDTH = 16,
  parameter int OUT_WIDTH  = ACT_W,
  parameter int TAPS       = 9,
  parameter int SHIFT      = 4,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  input  logic                         in_last,
  input  logic signed [BIAS_WIDTH-1:0] in_bias,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err_tap
);

  // Counter must reach TAPS+1 so an over-long window stays distinguishable.
  localparam int CNT_W = $clog2(TAPS + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TAPS = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TAPS + 1);

  accum_state_e                r_state;
  accum_state_e                w_state_next;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic signed [ACC_WIDTH-1:0] w_data_ext;
  logic signed [ACC_WIDTH-1:0] w_bias_ext;
  logic [CNT_W-1:0]            r_tap_cnt;
  logic [CNT_W-1:0]            w_cnt_next;
  logic signed [OUT_WIDTH-1:0] r_out_data;
  logic signed [OUT_WIDTH-1:0] w_req;
  logic                        r_out_valid;
  logic                        r_err_tap;
  logic                        w_accept;
  logic                        w_close;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_close    = w_accept && in_last;
  assign w_data_ext = ACC_WIDTH'(in_data);
  assign w_bias_ext = ACC_WIDTH'(in_bias);

  // Next accumulator, tap count and state for the current beat.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_tap_cnt;
    case (r_state)
      FIRST: begin
        if (w_accept) begin
          w_acc_next   = w_bias_ext + w_data_ext;
          w_cnt_next   = CNT_ONE;
          w_state_next = in_last ? FIRST : ACCUM;
        end else begin
          w_state_next = FIRST;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_acc_next   = r_acc + w_data_ext;
          w_cnt_next   = (r_tap_cnt == CNT_MAX) ? CNT_MAX : r_tap_cnt + CNT_ONE;
          w_state_next = in_last ? FIRST : ACCUM;
        end else begin
          w_state_next = ACCUM;
        end
      end
      default: begin
        w_state_next = FIRST;
      end
    endcase
  end

  // The closing beat's sum (w_acc_next) feeds requant directly: latency 1.
  cnn_core_requant #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT),
    .RELU_EN   (RELU_EN)
  ) u_requant (
    .i_acc (w_acc_next),
    .o_act (w_req)
  );

  // Window state, accumulator and tap counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state   <= FIRST;
      r_acc     <= '0;
      r_tap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_acc     <= w_acc_next;
      r_tap_cnt <= w_cnt_next;
    end
  end

  // Output register: a close can only happen when the slot is free or draining.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_close) begin
      r_out_data  <= w_req;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Sticky window-length error.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_err_tap <= 1'b0;
    end else if (w_close && (w_cnt_next != CNT_TAPS)) begin
      r_err_tap <= 1'b1;
    end else begin
      r_err_tap <= r_err_tap;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err_tap   = r_err_tap;

endmodule

// File: tb/tb_cnn_core_conv_accum.sv
// Scoreboard bench: two instances (ReLU on / off) share one input stream;
// expected activations are queued per window and popped by per-instance monitors.
module tb_cnn_core_conv_accum;

  logic               ap_clk;
  logic               ap_rst_n;
  logic signed [20:0] in_data;
  logic               in_last;
  logic signed [15:0] in_bias;
  logic               in_valid;
  logic               out_ready;
  logic               in_ready_r, in_ready_n;
  logic signed [15:0] out_data_r, out_data_n;
  logic               out_valid_r, out_valid_n;
  logic               err_tap_r, err_tap_n;

  int n_checks;
  int n_fail;
  int q_r[$];
  int q_n[$];

  cnn_core_conv_accum #(.RELU_EN(1'b1)) u_dut_relu (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_last(in_last),
    .in_bias(in_bias), .in_valid(in_valid), .in_ready(in_ready_r),
    .out_data(out_data_r), .out_valid(out_valid_r), .out_ready(out_ready),
    .err_tap(err_tap_r)
  );

  cnn_core_conv_accum #(.RELU_EN(1'b0)) u_dut_norelu (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_last(in_last),
    .in_bias(in_bias), .in_valid(in_valid), .in_ready(in_ready_n),
    .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready),
    .err_tap(err_tap_n)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the ReLU instance.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid_r && out_ready) begin
      if (q_r.size() == 0) begin
        chk("relu_unexpected_output", 1, 0);
      end else begin
        chk("relu_out_data", int'(out_data_r), q_r.pop_front());
      end
    end
  end

  // Monitor for the non-ReLU instance.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid_n && out_ready) begin
      if (q_n.size() == 0) begin
        chk("norelu_unexpected_output", 1, 0);
      end else begin
        chk("norelu_out_data", int'(out_data_n), q_n.pop_front());
      end
    end
  end

  // Present one beat until both instances accept it; inputs settle #1 after the edge.
  task automatic send_beat(input int val, input bit last, input int bias);
    bit acc;
    in_data  = 21'(val);
    in_last  = last;
    in_bias  = 16'(bias);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge ap_clk);
      acc = in_ready_r && in_ready_n;
      @(posedge ap_clk);
      #1;
    end
    if (!acc) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic send_window(input int n, input int val, input int bias);
    for (int i = 0; i < n; i++) begin
      send_beat(val, (i == n - 1), bias);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q_r.size() != 0 || q_n.size() != 0) && t < 50) begin
      @(posedge ap_clk);
      t++;
    end
    #1;
    chk("drain_relu_q", q_r.size(), 0);
    chk("drain_norelu_q", q_n.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ap_rst_n  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bias   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("rst_out_valid", int'(out_valid_r) + int'(out_valid_n), 0);
    chk("rst_out_data", int'(out_data_r), 0);
    chk("rst_err_tap", int'(err_tap_r) + int'(err_tap_n), 0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // Nominal: 9 x 100 -> (900+8)>>>4 = 56, visible the cycle after the last beat.
    q_r.push_back(56); q_n.push_back(56);
    send_window(9, 100, 0);
    chk("latency_out_valid", int'(out_valid_r), 1);
    wait_drain();
    chk("nominal_err_tap", int'(err_tap_r), 0);

    // Negative: -900 -> ReLU 0, otherwise (-892)>>>4 = -56.
    q_r.push_back(0); q_n.push_back(-56);
    send_window(9, -100, 0);
    // Saturation high: 9*1048575 -> 32767.
    q_r.push_back(32767); q_n.push_back(32767);
    send_window(9, 1048575, 0);
    // Saturation low: 9*-1048576 -> -32768 (ReLU 0).
    q_r.push_back(0); q_n.push_back(-32768);
    send_window(9, -1048576, 0);
    // Bias only: (16+8)>>>4 = 1.
    q_r.push_back(1); q_n.push_back(1);
    send_window(9, 0, 16);
    wait_drain();
    chk("after_sat_err_tap", int'(err_tap_n), 0);

    // Backpressure: hold the first result while the next window waits.
    out_ready = 1'b0;
    q_r.push_back(56); q_n.push_back(56);
    send_window(9, 100, 0);
    q_r.push_back(0); q_n.push_back(-56);
    in_data = -21'sd100; in_last = 1'b0; in_bias = '0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("bp_in_ready_low", int'(in_ready_r), 0);
      chk("bp_out_valid_held", int'(out_valid_n), 1);
      chk("bp_out_data_stable", int'(out_data_n), 56);
    end
    @(posedge ap_clk);
    #1 out_ready = 1'b1;
    send_window(9, -100, 0);
    wait_drain();

    // Short window of 5 x 16: (80+8)>>>4 = 5, err_tap sets and sticks.
    q_r.push_back(5); q_n.push_back(5);
    send_window(5, 16, 0);
    wait_drain();
    chk("tap_err_set", int'(err_tap_r), 1);
    q_r.push_back(56); q_n.push_back(56);
    send_window(9, 100, 0);
    wait_drain();
    chk("tap_err_sticky", int'(err_tap_n), 1);

    // Reset mid-window: partial sum discarded, no output for it.
    for (int i = 0; i < 4; i++) send_beat(100, 1'b0, 0);
    in_valid = 1'b0;
    ap_rst_n = 1'b0;
    repeat (2) begin
      @(negedge ap_clk);
      chk("midrst_out_valid", int'(out_valid_r) + int'(out_valid_n), 0);
    end
    chk("midrst_err_tap_cleared", int'(err_tap_r), 0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    q_r.push_back(56); q_n.push_back(56);
    send_window(9, 100, 0);
    wait_drain();
    repeat (5) @(posedge ap_clk);
    #1;
    chk("final_err_tap", int'(err_tap_r), 0);
    chk("final_no_extra", int'(out_valid_r) + int'(out_valid_n), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
